// File: rtl/splat_weight.sv
// splat_weight: per-pixel Gaussian splat weight.
// Stage 1 forms the quadratic-form terms a*dx^2, 2*b*dx*dy and c*dy^2.
// Stage 2 sums them into d^2, clamps negatives and flags the cutoff.
// Stage 3 waits for the registered LUT read.
// Stage 4 scales the LUT value by opacity.
// A single global enable stalls the whole pipeline under backpressure.
module splat_weight #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] dx,
    input  logic [DATA_W-1:0] dy,
    input  logic [COEF_W-1:0] conic_a,
    input  logic [COEF_W-1:0] conic_b,
    input  logic [COEF_W-1:0] conic_c,
    input  logic [7:0]        opacity,
    input  logic [15:0]       tag,
    output logic [10:0]       lut_addr,
    input  logic [15:0]       lut_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       weight,
    output logic [15:0]       m_tag
);

    // Wide enough that the three-term sum (< 3 * 2^38) cannot overflow.
    localparam int PW = 42;
    // d^2 of 8.0 in u4.18; at or beyond this the Gaussian is treated as zero.
    localparam logic [PW-1:0] CUTOFF_D2 = PW'(2097152);

    // Convert the signed s.22 sum to u4.18 d^2, clamp negatives to 0,
    // and return {cutoff, lut address}.
    function automatic logic [11:0] quant_d2(input logic signed [PW-1:0] s);
        logic signed [PW-1:0] sh;
        logic [PW-1:0]        d2;
        sh = s >>> 4;
        d2 = s[PW-1] ? '0 : $unsigned(sh);
        return {(d2 >= CUTOFF_D2), 11'(d2 >> 10)};
    endfunction

    // Scale the u0.16 LUT value by u0.8 opacity, keeping 16 bits.
    function automatic logic [15:0] scale_weight(input logic [15:0] lut,
                                                 input logic [7:0]  op,
                                                 input logic        cut);
        logic [23:0] prod;
        prod = {8'd0, lut} * {16'd0, op};
        return cut ? 16'd0 : 16'(prod >> 8);
    endfunction

    logic en;
    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    logic signed [PW-1:0] a_x, b_x, c_x, dx_x, dy_x;
    assign a_x  = {{(PW-COEF_W){1'b0}}, conic_a};
    assign c_x  = {{(PW-COEF_W){1'b0}}, conic_c};
    assign b_x  = {{(PW-COEF_W){conic_b[COEF_W-1]}}, conic_b};
    assign dx_x = {{(PW-DATA_W){dx[DATA_W-1]}}, dx};
    assign dy_x = {{(PW-DATA_W){dy[DATA_W-1]}}, dy};

    logic                 vld_p1, vld_p2, vld_p3;
    logic signed [PW-1:0] pa_p1, pb_p1, pc_p1;
    logic [7:0]           op_p1, op_p2, op_p3;
    logic [15:0]          tag_p1, tag_p2, tag_p3;
    logic                 cutoff_p2, cutoff_p3;
    logic [10:0]          addr_p2, addr_p3;

    logic signed [PW-1:0] sum_p2;
    logic [11:0]          quant_p2;
    assign sum_p2   = pa_p1 + pb_p1 + pc_p1;
    assign quant_p2 = quant_d2(sum_p2);

    // While stalled, keep addressing the S3 sample so lut_data stays aligned with it.
    assign lut_addr = en ? addr_p2 : addr_p3;

    // Control path: valid bits, addresses and output fields, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            m_valid <= 1'b0;
            addr_p2 <= '0;
            addr_p3 <= '0;
            weight  <= '0;
            m_tag   <= '0;
        end else if (en) begin
            vld_p1  <= s_valid;
            vld_p2  <= vld_p1;
            addr_p2 <= quant_p2[10:0];
            vld_p3  <= vld_p2;
            addr_p3 <= addr_p2;
            m_valid <= vld_p3;
            weight  <= scale_weight(lut_data, op_p3, cutoff_p3);
            m_tag   <= tag_p3;
        end
    end

    // Datapath registers: loaded on enable, no reset needed.
    always_ff @(posedge clk) begin
        if (en) begin
            // stage 1: quadratic-form terms, 22 fractional bits each
            pa_p1     <= a_x * dx_x * dx_x;
            pb_p1     <= (b_x * dx_x * dy_x) <<< 1;
            pc_p1     <= c_x * dy_x * dy_x;
            op_p1     <= opacity;
            tag_p1    <= tag;
            // stage 2: d^2 cutoff flag
            cutoff_p2 <= quant_p2[11];
            op_p2     <= op_p1;
            tag_p2    <= tag_p1;
            // stage 3: aligned with the LUT read
            cutoff_p3 <= cutoff_p2;
            op_p3     <= op_p2;
            tag_p3    <= tag_p2;
        end
    end

endmodule

// File: doc/splat_weight.md
SPLAT_WEIGHT -- requirements
Module: splat_weight

Interface
REQ-001 The module SHALL have these ports, in this order; clk and reset come first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid && s_ready.
- dx  in  12  signed s7.4 pixel offset from splat centre, X.
- dy  in  12  signed s7.4 pixel offset from splat centre, Y.
- conic_a  in  16  unsigned u2.14 conic xx term.
- conic_b  in  16  signed s1.14 conic xy term.
- conic_c  in  16  unsigned u2.14 conic yy term.
- opacity  in  8  u0.8 splat opacity.
- tag  in  16  opaque pixel tag, passed through unchanged.
- lut_addr  out  11  Gaussian LUT address (d² in u4.18, >>10).
- lut_data  in  16  u0.16 LUT value; registered, 1-cycle read latency.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- weight  out  16  u0.16 opacity-scaled Gaussian weight.
- m_tag  out  16  tag of the current output sample.

Function
REQ-002 The module SHALL use a 4-stage pipeline with one global enable en = !m_valid || m_ready; every stage register SHALL load only when en=1.
REQ-003 s_ready SHALL equal en; a sample is captured into S1 only when s_valid && s_ready.
REQ-004 S1 SHALL register three terms at full precision: pa = a*dx*dx, pb = 2*b*dx*dy, pc = c*dy*dy. Each term has 22 fractional bits.
REQ-005 S2 SHALL form sum = pa+pb+pc, signed, with no overflow possible at full precision, and shift it right 4 to get u4.18.
- A negative sum SHALL clamp to 0.
- A sum >= 8.0 (2097152 in u4.18) SHALL set the cutoff flag.
- S2 SHALL register d2_addr = d2[20:10].
REQ-006 lut_addr SHALL be combinational: lut_addr = en ? S2.d2_addr : S3.d2_addr. This keeps lut_data belonging to the S3 sample while the pipeline is stalled.
REQ-007 S3 SHALL carry valid, cutoff, opacity, tag and d2_addr, aligned with the lut_data arriving in the same cycle.
REQ-008 S4 (the output register) SHALL register the output fields:
- weight = cutoff ? 0 : (lut_data*opacity)>>8, truncated to 16 bits.
- m_tag = tag.
- m_valid = S3.valid.
REQ-009 Latency SHALL be exactly 4 cycles from input handshake to m_valid with no stalls. Throughput SHALL be 1 sample per cycle when m_ready=1.
REQ-010 While m_valid=1 and m_ready=0, weight, m_tag, m_valid and lut_addr SHALL be held stable, and no sample SHALL be lost or duplicated.
REQ-011 Pipeline bubbles SHALL NOT be collapsed. Output order SHALL equal input order.
REQ-012 A cutoff sample SHALL still be emitted, with weight=0 and a valid tag.
REQ-013 The datapath SHALL contain no other state: there is no FSM and no counters, only per-stage valid bits.

Reset
REQ-014 While reset=1, all stage valid bits, m_valid, weight and m_tag SHALL be 0 asynchronously. lut_addr SHALL be 0.
REQ-015 Reset asserted mid-stream SHALL discard all in-flight samples. After reset deasserts, s_ready SHALL be 1 on the first clock edge.
REQ-016 Datapath registers other than those listed in REQ-014 are don't-care after reset.

Verification
REQ-017 Origin sample: dx=0, dy=0, a=c=16384, b=0, opacity=255, lut returns 65535 -> lut_addr=0; weight=65279 four cycles after the handshake.
REQ-018 Unit distance: dx=16 (1.0), dy=0, a=c=16384, b=0 -> d2=262144; lut_addr=256; weight=(lut[256]*opacity)>>8.
REQ-019 Cutoff: dx=48 (3.0), dy=0, a=16384 -> d2=9.0; weight=0; m_tag preserved.
REQ-020 Negative clamp: dx=dy=16, a=c=16384, b=-24576 (-1.5) -> sum=-1.0; lut_addr=0; cutoff=0.
REQ-021 Backpressure: stream 6 tagged samples with m_ready low for 5 cycles mid-stream.
- s_ready drops once m_valid is held.
- All 6 emerge in order, correct weights, no duplicates.
- lut_addr stays stable throughout the stall.
REQ-022 Reset mid-stream: assert reset with 3 samples in flight -> m_valid=0 immediately; none of the 3 appear after release; a new sample emerges with 4-cycle latency.
